// File: rtl/my_pe_pkg.sv
// Shared types and constants for the my_pe floating-point MAC element and its sequencer.
package my_pe_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RD,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } pe_state_t;

endpackage

// File: rtl/my_pe_ctrl.sv
// Sequencer for the my_pe MAC element: clear psum, load B into PE RAM, issue A, return dot product.
// Optional WAIT watchdog with sticky err is enabled by defining MY_PE_CTRL_TIMEOUT_EN.
module my_pe_ctrl
  import my_pe_pkg::*;
#(
  parameter int L_RAM_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic [FP32_W-1:0]     s_b_tdata,
  input  logic                  s_b_tvalid,
  output logic                  s_b_tready,
  input  logic [FP32_W-1:0]     s_a_tdata,
  input  logic                  s_a_tvalid,
  output logic                  s_a_tready,
  output logic                  pe_rst_n,
  output logic [FP32_W-1:0]     pe_din,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [FP32_W-1:0]     pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [FP32_W-1:0]     pe_dout,
  output logic [FP32_W-1:0]     m_result_tdata,
  output logic                  m_result_tvalid,
  input  logic                  m_result_tready,
  output logic                  busy,
  output logic                  err
);

  localparam logic [L_RAM_SIZE:0]   LEN_ONE = 1;
  localparam logic [L_RAM_SIZE:0]   LEN_MAX = (L_RAM_SIZE+1)'(2**L_RAM_SIZE);
  localparam logic [L_RAM_SIZE-1:0] CNT_ONE = 1;

  pe_state_t               r_state;
  logic [L_RAM_SIZE:0]     r_len;
  logic [L_RAM_SIZE-1:0]   r_cnt;
  logic                    r_pe_rst_n;
  logic                    r_pe_we;
  logic                    r_pe_valid;
  logic [L_RAM_SIZE-1:0]   r_pe_addr;
  logic [FP32_W-1:0]       r_pe_din;
  logic [FP32_W-1:0]       r_pe_ain;
  logic [FP32_W-1:0]       r_result;

  logic w_start_ok;
  logic w_last;
  logic w_timeout;

  assign w_start_ok = start && (len != '0) && (len <= LEN_MAX);
  assign w_last     = ({1'b0, r_cnt} == (r_len - LEN_ONE));

`ifdef MY_PE_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_ONE = 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  assign w_timeout = (r_state == S_WAIT) && !pe_dvalid && (r_wd_cnt == WD_MAX);
  assign err       = r_err;

  // Counter restarts while in ISSUE, the only state that enters WAIT.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_wd_cnt <= '0;
      else if (r_state == S_WAIT)
        r_wd_cnt <= r_wd_cnt + WD_ONE;
      if (r_state == S_IDLE && w_start_ok)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_pe_rst_n <= 1'b0;
      r_pe_we    <= 1'b0;
      r_pe_valid <= 1'b0;
      r_pe_addr  <= '0;
      r_pe_din   <= '0;
      r_pe_ain   <= '0;
      r_result   <= '0;
    end else begin
      r_pe_we    <= 1'b0;
      r_pe_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pe_rst_n <= 1'b1;
          if (w_start_ok) begin
            r_len      <= len;
            r_cnt      <= '0;
            r_pe_rst_n <= 1'b0;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_pe_rst_n <= 1'b1;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          if (s_b_tvalid) begin
            r_pe_we   <= 1'b1;
            r_pe_addr <= r_cnt;
            r_pe_din  <= s_b_tdata;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_RD;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_RD: begin
          r_pe_addr <= r_cnt;
          r_state   <= S_ISSUE;
        end
        S_ISSUE: begin
          if (s_a_tvalid) begin
            r_pe_valid <= 1'b1;
            r_pe_ain   <= s_a_tdata;
            r_state    <= S_WAIT;
          end
        end
        // psum feeds back into the MAC, so the next A waits for this result.
        S_WAIT: begin
          if (pe_dvalid) begin
            if (w_last) begin
              r_result <= pe_dout;
              r_state  <= S_OUT;
            end else begin
              r_cnt   <= r_cnt + CNT_ONE;
              r_state <= S_RD;
            end
          end else if (w_timeout) begin
            r_pe_rst_n <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_OUT: begin
          if (m_result_tready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_b_tready      = (r_state == S_LOAD);
  assign s_a_tready      = (r_state == S_ISSUE);
  assign m_result_tvalid = (r_state == S_OUT);
  assign busy            = (r_state != S_IDLE);

  assign pe_rst_n       = r_pe_rst_n;
  assign pe_we          = r_pe_we;
  assign pe_valid       = r_pe_valid;
  assign pe_addr        = r_pe_addr;
  assign pe_din         = r_pe_din;
  assign pe_ain         = r_pe_ain;
  assign m_result_tdata = r_result;

endmodule

// File: tb/tb_my_pe_ctrl.sv
// Directed bench for my_pe_ctrl with a behavioural FP MAC element; watchdog test under MY_PE_CTRL_TIMEOUT_EN.
module tb_my_pe_ctrl;
  import my_pe_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic [31:0] s_b_tdata = '0;
  logic        s_b_tvalid = 1'b0;
  logic        s_b_tready;
  logic [31:0] s_a_tdata = '0;
  logic        s_a_tvalid = 1'b0;
  logic        s_a_tready;
  logic        pe_rst_n;
  logic [31:0] pe_din;
  logic [3:0]  pe_addr;
  logic        pe_we;
  logic [31:0] pe_ain;
  logic        pe_valid;
  logic        pe_dvalid = 1'b0;
  logic [31:0] pe_dout = '0;
  logic [31:0] m_result_tdata;
  logic        m_result_tvalid;
  logic        m_result_tready = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  my_pe_ctrl dut (
    .aclk(aclk), .areset(areset), .start(start), .len(len),
    .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready),
    .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
    .pe_rst_n(pe_rst_n), .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we),
    .pe_ain(pe_ain), .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout),
    .m_result_tdata(m_result_tdata), .m_result_tvalid(m_result_tvalid),
    .m_result_tready(m_result_tready), .busy(busy), .err(err)
  );

  always #5 aclk = ~aclk;

  // FP32 <-> real for normal numbers and zero, enough for the small integers used here.
  function automatic real s2r(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'd0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmac(input logic [31:0] acc, input logic [31:0] a,
                                       input logic [31:0] b);
    return r2s(s2r(acc) + s2r(a) * s2r(b));
  endfunction

  // Behavioural PE: RAM, bin sampled every edge, 3-cycle MAC latency, psum cleared by pe_rst_n.
  logic [31:0] pe_ram [16];
  logic [31:0] pe_bin = '0;
  logic [31:0] pe_psum = '0;
  logic [31:0] pe_pend = '0;
  int          pe_lat = 0;
  bit          pe_hang = 1'b0;

  always @(posedge aclk) begin
    if (pe_we) pe_ram[pe_addr] <= pe_din;
    pe_bin    <= pe_ram[pe_addr];
    pe_dvalid <= 1'b0;
    if (!pe_rst_n) begin
      pe_psum <= '0;
      pe_lat  <= 0;
    end else if (pe_valid) begin
      pe_pend <= fmac(pe_psum, pe_ain, pe_bin);
      pe_lat  <= 3;
    end else if (pe_lat == 1) begin
      pe_lat <= 0;
      if (!pe_hang) begin
        pe_dvalid <= 1'b1;
        pe_dout   <= pe_pend;
        pe_psum   <= pe_pend;
      end
    end else if (pe_lat > 1) begin
      pe_lat <= pe_lat - 1;
    end
  end

  int          n_valid = 0;
  int          n_we = 0;
  int          n_rstlow = 0;
  int          n_unstable = 0;
  logic        prev_tv = 1'b0;
  logic [31:0] prev_td = '0;

  always @(negedge aclk) begin
    if (pe_valid) n_valid <= n_valid + 1;
    if (pe_we) n_we <= n_we + 1;
    if (!pe_rst_n) n_rstlow <= n_rstlow + 1;
    if (m_result_tvalid && prev_tv && (m_result_tdata !== prev_td)) n_unstable <= n_unstable + 1;
    prev_tv <= m_result_tvalid;
    prev_td <= m_result_tdata;
  end

  task automatic do_start(input logic [4:0] l);
    start = 1'b1;
    len   = l;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic push(input bit is_a, input logic [31:0] d, input int gap, output bit ok);
    repeat (gap) @(negedge aclk);
    if (is_a) begin s_a_tdata = d; s_a_tvalid = 1'b1; end
    else      begin s_b_tdata = d; s_b_tvalid = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((is_a ? s_a_tready : s_b_tready) == 1'b1) begin
        ok = 1'b1;
        @(negedge aclk);
        break;
      end
      @(negedge aclk);
    end
    s_a_tvalid = 1'b0;
    s_b_tvalid = 1'b0;
  endtask

  task automatic wait_result(input int rdly, output logic [31:0] res, output bit ok);
    ok  = 1'b0;
    res = '0;
    for (int i = 0; i < 300; i++) begin
      if (m_result_tvalid) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (ok) begin
      res = m_result_tdata;
      repeat (rdly) @(negedge aclk);
      m_result_tready = 1'b1;
      @(negedge aclk);
      m_result_tready = 1'b0;
    end
  endtask

  task automatic run_op(input int n, input logic [31:0] b [16], input logic [31:0] a [16],
                        input bit gaps, input int rdly, output logic [31:0] res, output bit ok);
    bit hs;
    ok = 1'b1;
    do_start(5'(n));
    for (int i = 0; i < n; i++) begin
      push(1'b0, b[i], gaps ? (i % 3) : 0, hs);
      ok &= hs;
    end
    for (int i = 0; i < n; i++) begin
      push(1'b1, a[i], gaps ? ((i + 1) % 3) : 0, hs);
      ok &= hs;
    end
    wait_result(rdly, res, hs);
    ok &= hs;
    @(negedge aclk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge aclk);
    checks++;
    if ({pe_rst_n, pe_we, pe_valid, busy, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000", {pe_rst_n, pe_we, pe_valid, busy, err});
    end
    checks++;
    if ({s_a_tready, s_b_tready, m_result_tvalid} !== 3'b0) begin
      errors++;
      $display("FAIL reset_hs got %b required 000", {s_a_tready, s_b_tready, m_result_tvalid});
    end
    checks++;
    if ({m_result_tdata, pe_din, pe_ain, pe_addr} !== 100'b0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h required 0", m_result_tdata, pe_din, pe_ain, pe_addr);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (pe_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got pe_rst_n=%b busy=%b required 1/0", pe_rst_n, busy);
    end
  endtask

  task automatic test_basic;
    logic [31:0] b [16];
    logic [31:0] a [16];
    logic [31:0] res;
    bit ok;
    int v0, w0, r0;
    b = '{default: FP_ZERO};
    a = '{default: FP_ONE};
    b[0] = 32'h3F80_0000; b[1] = 32'h4000_0000; b[2] = 32'h4040_0000; b[3] = 32'h4080_0000;
    v0 = n_valid; w0 = n_we; r0 = n_rstlow;
    run_op(4, b, a, 1'b0, 0, res, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_handshake got timeout required completion"); end
    checks++;
    if (res !== 32'h4120_0000) begin errors++; $display("FAIL basic_result got %h required 41200000", res); end
    checks++;
    if (n_valid - v0 != 4) begin errors++; $display("FAIL basic_pe_valid got %0d required 4", n_valid - v0); end
    checks++;
    if (n_we - w0 != 4) begin errors++; $display("FAIL basic_pe_we got %0d required 4", n_we - w0); end
    checks++;
    if (n_rstlow - r0 != 1) begin errors++; $display("FAIL basic_rst_low got %0d required 1", n_rstlow - r0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b required 0", busy); end
  endtask

  task automatic test_psum_clear;
    logic [31:0] b [16];
    logic [31:0] a [16];
    logic [31:0] res;
    bit ok;
    b = '{default: FP_ZERO};
    a = '{default: FP_ZERO};
    b[0] = 32'h4040_0000;
    a[0] = 32'h4000_0000;
    run_op(1, b, a, 1'b0, 0, res, ok);
    checks++;
    if (!ok || res !== 32'h40C0_0000) begin
      errors++;
      $display("FAIL psum_clear got %h ok=%0d required 40c00000", res, ok);
    end
  endtask

  task automatic test_bad_len;
    int bad0, bad17, w0;
    bad0 = 0; bad17 = 0; w0 = n_we;
    do_start(5'd0);
    repeat (20) begin
      if (busy || s_b_tready || pe_we) bad0++;
      @(negedge aclk);
    end
    do_start(5'd17);
    repeat (20) begin
      if (busy || s_b_tready || pe_we) bad17++;
      @(negedge aclk);
    end
    checks++;
    if (bad0 != 0) begin errors++; $display("FAIL len0_ignored got %0d active cycles required 0", bad0); end
    checks++;
    if (bad17 != 0) begin errors++; $display("FAIL len17_ignored got %0d active cycles required 0", bad17); end
    checks++;
    if (n_we != w0) begin errors++; $display("FAIL badlen_we got %0d writes required 0", n_we - w0); end
  endtask

  task automatic test_gaps;
    logic [31:0] b [16];
    logic [31:0] a [16];
    logic [31:0] res;
    bit ok;
    int v0, u0;
    b = '{default: FP_ZERO};
    a = '{default: FP_ONE};
    b[0] = 32'h3F80_0000; b[1] = 32'h4000_0000; b[2] = 32'h4040_0000; b[3] = 32'h4080_0000;
    v0 = n_valid; u0 = n_unstable;
    run_op(4, b, a, 1'b1, 5, res, ok);
    checks++;
    if (!ok || res !== 32'h4120_0000) begin
      errors++;
      $display("FAIL gaps_result got %h ok=%0d required 41200000", res, ok);
    end
    checks++;
    if (n_valid - v0 != 4) begin errors++; $display("FAIL gaps_pe_valid got %0d required 4", n_valid - v0); end
    checks++;
    if (n_unstable != u0) begin errors++; $display("FAIL gaps_tdata_stable got %0d changes required 0", n_unstable - u0); end
  endtask

  task automatic test_max_len;
    logic [31:0] b [16];
    logic [31:0] a [16];
    logic [31:0] res;
    bit ok;
    int w0;
    b = '{default: FP_ONE};
    a = '{default: FP_ONE};
    w0 = n_we;
    run_op(16, b, a, 1'b0, 0, res, ok);
    checks++;
    if (!ok || res !== 32'h4180_0000) begin
      errors++;
      $display("FAIL maxlen_result got %h ok=%0d required 41800000", res, ok);
    end
    checks++;
    if (n_we - w0 != 16) begin errors++; $display("FAIL maxlen_pe_we got %0d required 16", n_we - w0); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] b [16];
    logic [31:0] a [16];
    logic [31:0] res;
    bit ok;
    int bad;
    do_start(5'd2);
    push(1'b0, 32'h4000_0000, 0, ok);
    push(1'b0, 32'h4040_0000, 0, ok);
    push(1'b1, 32'h4040_0000, 0, ok);
    checks++;
    if (busy !== 1'b1 || s_a_tready !== 1'b0 || s_b_tready !== 1'b0) begin
      errors++;
      $display("FAIL in_wait got busy=%b a_rdy=%b b_rdy=%b required 1/0/0", busy, s_a_tready, s_b_tready);
    end
    #1 areset = 1'b1;
    #1;
    checks++;
    if ({busy, pe_rst_n, pe_valid, pe_we, m_result_tvalid, s_a_tready, s_b_tready} !== 7'b0) begin
      errors++;
      $display("FAIL abort_ctrl got %b required 0000000",
               {busy, pe_rst_n, pe_valid, pe_we, m_result_tvalid, s_a_tready, s_b_tready});
    end
    checks++;
    if (m_result_tdata !== 32'd0 || pe_ain !== 32'd0) begin
      errors++;
      $display("FAIL abort_data got %h/%h required 0/0", m_result_tdata, pe_ain);
    end
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge aclk);
      if (m_result_tvalid) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_no_result got %0d valid cycles required 0", bad); end
    b = '{default: FP_ZERO};
    a = '{default: FP_ZERO};
    b[0] = 32'h4000_0000; b[1] = 32'h4040_0000;
    a[0] = 32'h4040_0000; a[1] = 32'h3F80_0000;
    run_op(2, b, a, 1'b0, 0, res, ok);
    checks++;
    if (!ok || res !== 32'h4110_0000) begin
      errors++;
      $display("FAIL after_abort got %h ok=%0d required 41100000", res, ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b [16];
    logic [31:0] a [16];
    logic [31:0] res;
    bit ok;
    b = '{default: FP_ONE};
    a = '{default: 32'h4000_0000};
    run_op(3, b, a, 1'b0, 0, res, ok);
    checks++;
    if (!ok || res !== 32'h40C0_0000) begin
      errors++;
      $display("FAIL back_to_back got %h ok=%0d required 40c00000", res, ok);
    end
  endtask

`ifdef MY_PE_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] res;
    bit ok;
    int cyc;
    pe_hang = 1'b1;
    do_start(5'd1);
    push(1'b0, FP_ONE, 0, ok);
    push(1'b1, FP_ONE, 0, ok);
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      cyc++;
      @(negedge aclk);
    end
    checks++;
    if (cyc != 64) begin errors++; $display("FAIL timeout_cycles got %0d required 64", cyc); end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || m_result_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state got err=%b busy=%b tvalid=%b required 1/0/0", err, busy, m_result_tvalid);
    end
    pe_hang = 1'b0;
    repeat (3) @(negedge aclk);
    do_start(5'd1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %b required 0", err); end
    push(1'b0, FP_ONE, 0, ok);
    push(1'b1, FP_ONE, 0, ok);
    wait_result(0, res, ok);
    checks++;
    if (!ok || res !== FP_ONE) begin
      errors++;
      $display("FAIL timeout_recover got %h ok=%0d required 3f800000", res, ok);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_psum_clear();
    test_bad_len();
    test_gaps();
    test_max_len();
    test_reset_in_wait();
    test_back_to_back();
`ifdef MY_PE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_pe_ctrl.md
Name: my_pe_ctrl

Overview:
- Sequencer directly upstream of the floating-point MAC PE (`my_pe`).
- Clears the PE accumulator, streams one B vector into the PE-local RAM, then issues A elements one at a time.
- After the last MAC completes, returns the dot product on an AXI-stream-style result port.
- Only one MAC is in flight at a time, because the PE feeds psum back into the MAC.

Parameters:
- L_RAM_SIZE, 4: PE RAM address width; maximum vector length is 2**L_RAM_SIZE.
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT; used only with the optional feature.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  L_RAM_SIZE+1  vector length, legal range 1..2**L_RAM_SIZE, latched on accepted start
- s_b_tdata  in  32  B element (IEEE-754 single)
- s_b_tvalid  in  1  B element valid
- s_b_tready  out  1  B element ready
- s_a_tdata  in  32  A element (IEEE-754 single)
- s_a_tvalid  in  1  A element valid
- s_a_tready  out  1  A element ready
- pe_rst_n  out  1  drives PE aresetn; clears the PE psum
- pe_din  out  32  PE RAM write data
- pe_addr  out  L_RAM_SIZE  PE RAM address
- pe_we  out  1  PE RAM write enable
- pe_ain  out  32  PE port A operand
- pe_valid  out  1  MAC issue strobe
- pe_dvalid  in  1  MAC result valid
- pe_dout  in  32  MAC result
- m_result_tdata  out  32  dot product
- m_result_tvalid  out  1  result valid
- m_result_tready  in  1  result ready
- busy  out  1  high in every state except IDLE
- err  out  1  watchdog error; constant 0 without the optional feature

Behaviour:
- Single clock aclk; reset areset is asynchronous and active-high.
- Reset: state IDLE and counters 0. All outputs 0, including pe_rst_n, so the PE is held in reset. tdata outputs are 0.
- Reset mid-operation aborts immediately. No partial result is ever emitted.
- All PE-side outputs (pe_*) are registered: a value decided in cycle k is visible in cycle k+1.
- s_*_tready and m_result_tvalid are decoded from state.
- IDLE:
  - pe_rst_n=1.
  - start with len in 1..2**L_RAM_SIZE: latch len, cnt=0, go to CLEAR.
  - start with len out of range: ignored; busy stays 0.
- CLEAR: drive pe_rst_n=0 for exactly one cycle, then go to LOAD.
- LOAD:
  - s_b_tready=1.
  - Each handshake registers pe_we=1, pe_addr=cnt, pe_din=s_b_tdata, then cnt++.
  - On the handshake with cnt==len-1: cnt=0, go to RD.
  - pe_we=0 in every cycle without a handshake.
- RD:
  - Register pe_we=0, pe_addr=cnt; go to ISSUE.
  - The PE samples its bin at the end of the ISSUE cycle.
- ISSUE:
  - s_a_tready=1.
  - On handshake: register pe_valid=1 (one-cycle pulse) and pe_ain=s_a_tdata; go to WAIT.
  - While s_a_tvalid=0, stay in ISSUE with pe_addr held.
- WAIT:
  - pe_valid=0.
  - On pe_dvalid with cnt==len-1: latch pe_dout into m_result_tdata, go to OUT.
  - On pe_dvalid otherwise: cnt++, go to RD.
- OUT:
  - m_result_tvalid=1; data stable until handshake.
  - On m_result_tready: go to IDLE.
- Counts per operation: exactly len pe_we pulses, len pe_valid pulses, len A handshakes.
- pe_dvalid outside WAIT is ignored.
- start while busy is ignored.
- Throughput: minimum 2 + MAC latency cycles per element.

Optional Feature:
- Macro: MY_PE_CTRL_TIMEOUT_EN.
- With the macro:
  - A watchdog counter runs in WAIT and resets on each entry to WAIT.
  - On reaching TIMEOUT_CYCLES without pe_dvalid: set err=1 (sticky), drive pe_rst_n=0 for one cycle, go to IDLE. No result is emitted.
  - err clears on the next accepted start or on areset.
- Without the macro: err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package my_pe_pkg holds:
  - state encoding enum (IDLE, CLEAR, LOAD, RD, ISSUE, WAIT, OUT);
  - FP32 width constant;
  - FP constants ZERO=0x00000000 and ONE=0x3F800000 for benches.
- No sub-module is required.
- The watchdog may be a small sub-module, my_pe_ctrl_wdog, instantiated only under the macro.

Test Plan:
- len=4, B={0x3F800000,0x40000000,0x40400000,0x40800000}, A all 0x3F800000 -> m_result_tdata=0x41200000 (10.0); 4 pe_valid pulses; 1 pe_rst_n low cycle.
- Run above, then len=1, A=0x40000000, B=0x40400000 -> 0x40C00000 (6.0), confirming the psum is cleared between operations.
- start with len=0, and with len=17 -> busy, s_b_tready, pe_we stay 0 for 20 cycles.
- Random s_a_tvalid and s_b_tvalid gaps plus m_result_tready low for 5 cycles -> same result, m_result_tdata stable while tvalid is high, no duplicate pe_valid.
- areset asserted in WAIT -> outputs 0 in the same cycle, no m_result_tvalid; a following len=2 operation computes correctly.
- MY_PE_CTRL_TIMEOUT_EN with PE model that never raises pe_dvalid -> err=1 after 64 WAIT cycles, busy=0; the next accepted start clears err.
